// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants for the median window fetch sequencer
package median_pkg;

    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;
    localparam int ADDR_W_DEF = 6;
    localparam int TAP_NUM    = 9;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_FETCH   = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

endpackage

// File: rtl/median_tap_gen.sv
// rtl/median_tap_gen.sv - combinational 3x3 tap address and out-of-bounds flag
module median_tap_gen
    import median_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    input  logic [3:0]        tap,
    output logic [ADDR_W-1:0] addr,
    output logic              pad
);

    localparam logic signed [4:0] W_S = 5'(IMG_W);
    localparam logic signed [4:0] H_S = 5'(IMG_H);

    logic [1:0]        dr;
    logic [1:0]        dc;
    logic signed [4:0] r;
    logic signed [4:0] c;
    logic [15:0]       lin;

    always_comb begin
        dr  = 2'(tap / 4'd3);
        dc  = 2'(tap % 4'd3);
        // Signed 5-bit so that row/col 0 minus one becomes -1 rather than wrapping.
        r   = $signed({2'b00, row}) + $signed({3'b000, dr}) - 5'sd1;
        c   = $signed({2'b00, col}) + $signed({3'b000, dc}) - 5'sd1;
        pad = (r < 5'sd0) || (r >= H_S) || (c < 5'sd0) || (c >= W_S);
        lin = 16'($unsigned(r)) * 16'(IMG_W) + 16'($unsigned(c));
        addr = pad ? '0 : lin[ADDR_W-1:0];
    end

endmodule

// File: rtl/median_window_fetch.sv
// rtl/median_window_fetch.sv - fetches a zero-padded 3x3 window into the median unit
module median_window_fetch
    import median_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_row,
    input  logic [2:0]        i_col,
    output logic              o_busy,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_med_clear,
    output logic              o_med_active,
    output logic [7:0]        o_med_data,
    input  logic [7:0]        i_med_median,
    output logic              o_out_valid,
    output logic [7:0]        o_out_data
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        tap_q, tap_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic              pad_q, pad_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [ADDR_W-1:0] tap_addr;
    logic              tap_pad;
    logic              rd_phase;

    median_tap_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_tap_gen (
        .row  (row_q),
        .col  (col_q),
        .tap  (tap_q),
        .addr (tap_addr),
        .pad  (tap_pad)
    );

    // tap_q is the tap whose address is on the bus; FETCH k shows tap k+1.
    assign rd_phase = (state_q == S_CLEAR) ||
                      ((state_q == S_FETCH) && (tap_q < 4'(TAP_NUM)));

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        row_d       = row_q;
        col_d       = col_q;
        pad_d       = rd_phase ? tap_pad : 1'b1;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CLEAR;
                    row_d   = i_row;
                    col_d   = i_col;
                    tap_d   = 4'd0;
                end
            end
            S_CLEAR: begin
                state_d = S_FETCH;
                tap_d   = 4'd1;
            end
            S_FETCH: begin
                if (tap_q == 4'(TAP_NUM)) begin
                    state_d = S_CAPTURE;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                state_d     = S_IDLE;
                tap_d       = 4'd0;
                out_valid_d = 1'b1;
                out_data_d  = i_med_median;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            tap_q       <= 4'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            pad_q       <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pad_q       <= pad_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_med_clear  = (state_q == S_CLEAR);
    assign o_med_active = (state_q == S_FETCH);
    assign o_med_data   = (o_med_active && !pad_q) ? i_rd_data : 8'd0;
    assign o_rd_en      = rd_phase && !tap_pad;
    assign o_rd_addr    = o_rd_en ? tap_addr : '0;
    assign o_out_valid  = out_valid_q;
    assign o_out_data   = out_data_q;

endmodule

// File: tb/tb_median_window_fetch.sv
// tb/tb_median_window_fetch.sv - self-checking bench with SRAM and median unit models
module tb_median_window_fetch;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [2:0] i_row = 3'd0;
    logic [2:0] i_col = 3'd0;
    logic       o_busy;
    logic       o_rd_en;
    logic [5:0] o_rd_addr;
    logic [7:0] i_rd_data = 8'd0;
    logic       o_med_clear;
    logic       o_med_active;
    logic [7:0] o_med_data;
    logic [7:0] i_med_median;
    logic       o_out_valid;
    logic [7:0] o_out_data;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] mem   [64];
    logic [7:0] med_s [9];

    median_window_fetch dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_row        (i_row),
        .i_col        (i_col),
        .o_busy       (o_busy),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_med_clear  (o_med_clear),
        .o_med_active (o_med_active),
        .o_med_data   (o_med_data),
        .i_med_median (i_med_median),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] median_of(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 8 - a; b++)
                if (s[b] > s[b+1]) begin
                    t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                end
        return s[4];
    endfunction

    always @(posedge i_clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    // Median unit: clear empties, each active strobe inserts one sample.
    always @(posedge i_clk) begin
        if (o_med_clear) begin
            for (int i = 0; i < 9; i++) med_s[i] <= 8'd0;
        end else if (o_med_active) begin
            med_s[0] <= o_med_data;
            for (int i = 1; i < 9; i++) med_s[i] <= med_s[i-1];
        end
    end

    always_comb i_med_median = median_of(med_s);

    function automatic logic [7:0] ref_median(input int r, input int c);
        logic [7:0] v [9];
        int rr, cc;
        for (int k = 0; k < 9; k++) begin
            rr = r - 1 + k / 3;
            cc = c - 1 + k % 3;
            v[k] = (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) ? mem[rr*8+cc] : 8'd0;
        end
        return median_of(v);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(o_busy), 0);
        chk({tag, "_rd_en"},  int'(o_rd_en), 0);
        chk({tag, "_rd_addr"},int'(o_rd_addr), 0);
        chk({tag, "_clear"},  int'(o_med_clear), 0);
        chk({tag, "_active"}, int'(o_med_active), 0);
        chk({tag, "_mdata"},  int'(o_med_data), 0);
        chk({tag, "_valid"},  int'(o_out_valid), 0);
        chk({tag, "_odata"},  int'(o_out_data), 0);
    endtask

    // Caller has i_start/i_row/i_col set up before the accepting edge.
    task automatic run_window(input int r, input int c, input logic [15:0] repulse,
                              input bit chain, input int nr, input int nc);
        int exp_addr[$];
        int got_addr[$];
        int n_act = 0, n_clr = 0, n_val = 0, n_ovl = 0, busy_bad = 0, val_at = -1;
        int got_data = -1;
        int rr, cc;
        logic [7:0] exp_med;
        exp_med = ref_median(r, c);
        for (int k = 0; k < 9; k++) begin
            rr = r - 1 + k / 3;
            cc = c - 1 + k % 3;
            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) exp_addr.push_back(rr * 8 + cc);
        end
        @(posedge i_clk);
        #1 i_start = 1'b0;
        for (int i = 0; i <= 11; i++) begin
            @(negedge i_clk);
            if (o_rd_en) got_addr.push_back(int'(o_rd_addr));
            if (o_med_active) n_act++;
            if (o_med_clear) n_clr++;
            if (o_med_active && o_med_clear) n_ovl++;
            if (o_out_valid) begin
                n_val++;
                val_at = i;
                got_data = int'(o_out_data);
                chk("busy_at_valid", int'(o_busy), 0);
            end else if (o_busy !== 1'b1) begin
                busy_bad++;
            end
            if (i < 11) begin
                @(posedge i_clk);
                #1;
                i_start = repulse[i+1];
                if (repulse[i+1]) begin
                    i_row = 3'($urandom_range(0, 7));
                    i_col = 3'($urandom_range(0, 7));
                end
            end
        end
        if (chain) begin
            i_start = 1'b1;
            i_row = 3'(nr);
            i_col = 3'(nc);
        end else begin
            i_start = 1'b0;
            @(posedge i_clk);
            #1;
            @(negedge i_clk);
            if (o_out_valid) n_val++;
            chk("idle_after", int'(o_busy), 0);
        end
        chk("latency", val_at, 11);
        chk("valid_count", n_val, 1);
        chk("median", got_data, int'(exp_med));
        chk("active_count", n_act, 9);
        chk("clear_count", n_clr, 1);
        chk("clear_active_overlap", n_ovl, 0);
        chk("busy_window", busy_bad, 0);
        chk("read_count", got_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
            chk("read_addr", got_addr[k], exp_addr[k]);
    endtask

    task automatic fill_ident();
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    endtask

    initial begin
        int r, c;
        logic [15:0] rp;
        fill_ident();
        for (int i = 0; i < 9; i++) med_s[i] = 8'd0;

        #12;
        chk_all_zero("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        i_start = 1'b1; i_row = 3'd3; i_col = 3'd3;
        run_window(3, 3, 16'h0, 1'b0, 0, 0);
        chk("t1_const", int'(o_out_data), 27);

        i_start = 1'b1; i_row = 3'd0; i_col = 3'd0;
        run_window(0, 0, 16'h0, 1'b0, 0, 0);
        chk("t2_const", int'(o_out_data), 0);

        for (int a = 0; a < 64; a++) mem[a] = 8'hFF;
        i_start = 1'b1; i_row = 3'd0; i_col = 3'd3;
        run_window(0, 3, 16'h0, 1'b0, 0, 0);
        chk("t3a_const", int'(o_out_data), 255);
        i_start = 1'b1; i_row = 3'd7; i_col = 3'd7;
        run_window(7, 7, 16'h0, 1'b0, 0, 0);
        chk("t3b_const", int'(o_out_data), 0);

        fill_ident();
        i_start = 1'b1; i_row = 3'd5; i_col = 3'd2;
        run_window(5, 2, 16'h0208, 1'b0, 0, 0);
        chk("t4_const", int'(o_out_data), 42);

        i_start = 1'b1; i_row = 3'd1; i_col = 3'd1;
        run_window(1, 1, 16'h0, 1'b1, 6, 6);
        chk("t5a_const", int'(o_out_data), 9);
        run_window(6, 6, 16'h0, 1'b0, 0, 0);
        chk("t5b_const", int'(o_out_data), 54);

        i_start = 1'b1; i_row = 3'd4; i_col = 3'd4;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            chk("midreset_valid", int'(o_out_valid), 0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_reset_idle", int'(o_busy), 0);
        i_start = 1'b1; i_row = 3'd2; i_col = 3'd5;
        run_window(2, 5, 16'h0, 1'b0, 0, 0);
        chk("t6_const", int'(o_out_data), 21);

        for (int n = 0; n < 10; n++) begin
            for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
            r  = $urandom_range(0, 7);
            c  = $urandom_range(0, 7);
            rp = 16'($urandom_range(0, 65535)) & 16'h07FE;
            i_start = 1'b1; i_row = 3'(r); i_col = 3'(c);
            run_window(r, c, rp, 1'b0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
